sigmoid_sonf_core: RTL and testbench
====================================

// Module: sigmoid_sonf_core
// PURPOSE
//  Pipelined fixed-point sigmoid for CNN activation layers.
//  Uses the second-order nonlinear function (SONF) approximation, with L = 4:
//    x >= 4      : y = 1
//    0 <= x < 4  : y = 1 - 0.5*(1 - x/4)^2
//    -4 < x < 0  : y = 0.5*(1 + x/4)^2
//    x <= -4     : y = 0
//  Sits after a conv/FC accumulator; accepts one sample per clock; no backpressure.
// PARAMETERS
//  XW  17  input width, signed two's complement, Q4.12 (XF = 12 fraction bits)
//  XF  12  input fraction bits; output fraction bits = 2*XF = 24
//  YW  33  output width, signed, Q8.24; 1.0 = 2^24 = 16777216
//  Only the defaults are verified; the design requires YW >= 2*XF + 2.
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous active-high reset
//  in_valid   in   1   x is valid this cycle
//  x          in   17  signed Q4.12 input (-16.0 .. +15.99976)
//  out_valid  out  1   y is valid this cycle
//  y          out  33  signed Q8.24 sigmoid, range 0 .. 16777216
// BEHAVIOUR
//  - Reset: while rst=1, all pipeline registers are 0, including out_valid=0 and y=0.
//    Reset is asynchronous, with immediate effect. In-flight samples are discarded.
//  - Latency: exactly 3 clk from (in_valid=1, x) sampled to (out_valid=1, y). Throughput 1/clk.
//  - out_valid is in_valid delayed 3 cycles. y updates only when the sample is valid.
//    y holds its last value when out_valid=0.
//  - S1: sign s = x[16]; a = |x| computed in 18 bits, so x = -65536 does not overflow.
//    sat = (a >= 16384), i.e. |x| >= 4.0; t = 16384 - a (14..15 bit unsigned, Q2.12).
//  - S2: p = t*t, unsigned, 29 bits, Q.24 (max 2^28); sat and s are carried along.
//  - S3: q = p >> 5 (truncating; see CONFIGURATION).
//    sat & !s  -> y = 16777216
//    sat &  s  -> y = 0
//    !sat & !s -> y = 16777216 - q  (x >= 0)
//    !sat &  s -> y = q
//    y is zero-extended to YW bits, so it is never negative.
//  - x = 0 gives exactly 8388608 (0.5). Output is monotonic non-decreasing in x.
//  - Symmetry: y(x) + y(-x) = 16777216 exactly for all |x| < 65536.
//  - Boundaries: x = +16384 and x = -16384 take the saturated branch.
//    x = 16383 gives 16777216 - 0 (q = 0).
//  - No internal state beyond the pipeline; no overflow paths at S3.
// CONFIGURATION
//  SIGMOID_ROUND_EN
//    defined:   q = (p + 16) >> 5, round half up; applied identically to both
//               signs, so symmetry holds.
//    undefined: q = p >> 5, truncation.
//  Latency and ports are unchanged either way.
// TESTING
//  1 x=0 -> 3 cycles later out_valid=1, y=8388608.
//  2 x=8192 (2.0) -> y=14680064; x=-8192 -> y=2097152.
//  3 x=16384, 65535 -> y=16777216; x=-16384, -65536 -> y=0.
//  4 x=-5 -> y=8383488 (truncate) or 8383489 (SIGMOID_ROUND_EN);
//    x=5 -> y = 16777216 minus the same value.
//  5 sweep x=-65535..65535 step 100, in_valid=1 every cycle -> out_valid continuous;
//    y monotonic; y(x)+y(-x) = 16777216; matches a golden model bit-exactly.
//  6 rst asserted mid-stream -> out_valid=0 and y=0 immediately.
//    First valid output appears 3 cycles after the first in_valid following release.

Source files
------------

// File: rtl/sigmoid_sonf_core_if.sv
// Streaming bus for the SONF sigmoid core: one sample in, one sample out
// per clock, no backpressure. The producer side (conv/FC accumulator or
// bench) uses the master modport; the core uses the slave modport.
interface sigmoid_sonf_core_if #(
  parameter int XW = 17,
  parameter int YW = 33
);
  logic          in_valid;
  logic [XW-1:0] x;
  logic          out_valid;
  logic [YW-1:0] y;

  modport master (output in_valid, output x, input out_valid, input y);
  modport slave  (input in_valid, input x, output out_valid, output y);
endinterface

// File: rtl/sigmoid_sonf_core.sv
// sigmoid_sonf_core: 3-stage pipelined fixed-point sigmoid using the
// second-order nonlinear approximation with L = 4.
//   x: signed Q4.12 (17 bits), y: Q8.24 (33 bits), 1.0 = 2^24.
//   S1: sign, magnitude, saturation flag, t = 4.0 - |x|
//   S2: p = t*t
//   S3: q = p/32, fold into y by sign/saturation
// Optional feature macro: SIGMOID_ROUND_EN
//   defined   -> q = (p + 16) >> 5 (round half up)
//   undefined -> q = p >> 5 (truncate)
// Latency and ports are identical in both builds.
module sigmoid_sonf_core #(
  parameter int XW = 17,
  parameter int XF = 12,
  parameter int YW = 33
) (
  input  logic               clk,
  input  logic               rst,
  sigmoid_sonf_core_if.slave bus
);

  // Magnitude is one bit wider than x so that |-2^(XW-1)| is representable.
  localparam int AW = XW + 1;
  // t = 4.0 - |x| in Q2.12 needs XF+3 bits (max value 4.0 = 2^(XF+2)).
  localparam int TW = XF + 3;
  // t*t never exceeds 2^(2*XF+4), so one bit less than the full product.
  localparam int PW = 2 * TW - 1;
  // (t/4)^2 / 2 in Q(2*XF): t^2 * 2^-(2*XF+5) * 2^(2*XF) = t^2 >> 5.
  localparam int SH = 5;

  localparam logic [AW-1:0] LIM   = AW'(1) << (XF + 2);
  localparam logic [YW-1:0] ONE_Y = YW'(1) << (2 * XF);

  // Stage 1 registers
  logic          v1;
  logic          s1;
  logic          sat1;
  logic [TW-1:0] t1;

  // Stage 2 registers
  logic          v2;
  logic          s2;
  logic          sat2;
  logic [PW-1:0] p2;

  // Stage 3 (output) registers
  logic          v3;
  logic [YW-1:0] y3;

  // Stage 1 combinational terms
  logic [AW-1:0] xe;
  logic [AW-1:0] a_n;
  logic          sat_n;
  logic [TW-1:0] t_n;

  // Stage 2 combinational terms
  logic [2*TW-1:0] p_full;

  // Stage 3 combinational terms
  logic [PW:0]   pr;
  logic [YW-1:0] q_ext;
  logic [YW-1:0] y_n;

  assign xe = {bus.x[XW-1], bus.x};

  // Magnitude, saturation and distance from the knee at |x| = 4.0.
  // t is forced to zero when saturated so the multiplier never sees a
  // wrapped value; the saturated branch ignores it anyway.
  always_comb begin
    a_n = xe;
    if (xe[AW-1]) a_n = ~xe + AW'(1);
    sat_n = (a_n >= LIM);
    t_n   = '0;
    if (!sat_n) t_n = TW'(LIM - a_n);
  end

  assign p_full = {{TW{1'b0}}, t1} * {{TW{1'b0}}, t1};

  // Scale the square down to Q.24 of 0.5*(1-|x|/4)^2. Rounding is applied
  // to the magnitude before the sign fold, so y(x) + y(-x) stays exactly 1.0.
  always_comb begin
`ifdef SIGMOID_ROUND_EN
    pr = {1'b0, p2} + (PW+1)'(16);
`else
    pr = {1'b0, p2};
`endif
    q_ext = YW'(pr >> SH);
    unique case ({sat2, s2})
      2'b10:   y_n = ONE_Y;
      2'b11:   y_n = '0;
      2'b00:   y_n = ONE_Y - q_ext;
      default: y_n = q_ext;
    endcase
  end

  // Stage 1: capture sign, saturation and t for every incoming cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      s1   <= 1'b0;
      sat1 <= 1'b0;
      t1   <= '0;
    end else begin
      v1   <= bus.in_valid;
      s1   <= bus.x[XW-1];
      sat1 <= sat_n;
      t1   <= t_n;
    end
  end

  // Stage 2: square t and carry the branch selectors alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      s2   <= 1'b0;
      sat2 <= 1'b0;
      p2   <= '0;
    end else begin
      v2   <= v1;
      s2   <= s1;
      sat2 <= sat1;
      p2   <= p_full[PW-1:0];
    end
  end

  // Stage 3: y changes only for valid samples and holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3 <= 1'b0;
      y3 <= '0;
    end else begin
      v3 <= v2;
      if (v2) y3 <= y_n;
    end
  end

  assign bus.out_valid = v3;
  assign bus.y         = y3;

endmodule

// File: tb/tb_sigmoid_sonf_core.sv
// Self-checking bench for sigmoid_sonf_core. Expected results are queued
// with the cycle they were driven and popped when out_valid appears.
// Honors SIGMOID_ROUND_EN the same way as the core.
module tb_sigmoid_sonf_core;

  localparam int  XW    = 17;
  localparam int  YW    = 33;
  localparam longint ONE = 64'd16777216;
  localparam int  NSWP  = 1311;

  logic clk;
  logic rst;

  sigmoid_sonf_core_if #(.XW(XW), .YW(YW)) bus ();

  sigmoid_sonf_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    longint expY;
    longint cyc;
    int     kind;
    int     idx;
  } sbEntry;

  sbEntry sbQ[$];
  longint cycle;
  int     passCount;
  int     checkCount;
  longint lastY;
  longint upY [NSWP];
  longint dnY [NSWP];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference sigmoid, written straight from the piecewise SONF formula.
  function automatic longint model(input int xv);
    longint a, t, p, q;
    a = (xv < 0) ? -xv : xv;
    if (a >= 16384) return (xv < 0) ? 0 : ONE;
    t = 16384 - a;
    p = t * t;
`ifdef SIGMOID_ROUND_EN
    q = (p + 16) / 32;
`else
    q = p / 32;
`endif
    return (xv < 0) ? q : ONE - q;
  endfunction

  // Drive one cycle of input; valid samples queue their expected result.
  task automatic applyStimulus(input logic v, input int xv, input longint expY,
                               input int kind, input int idx);
    sbEntry e;
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.x        = xv[XW-1:0];
    if (v) begin
      e.expY = expY;
      e.cyc  = cycle + 3;
      e.kind = kind;
      e.idx  = idx;
      sbQ.push_back(e);
    end
  endtask

  // Wait for all queued samples to emerge, bounded.
  task automatic drain();
    int n;
    n = 0;
    applyStimulus(1'b0, 0, 0, 0, 0);
    while (sbQ.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_empty", sbQ.size(), 0);
  endtask

  // Output monitor, sampling mid-cycle away from the rising edge.
  always @(negedge clk) begin
    sbEntry e;
    if (!rst) begin
      if (bus.out_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("spurious_valid", 1, 0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("latency", cycle, e.cyc);
          checkOutput("y", longint'(bus.y), e.expY);
          if (e.kind == 1) begin
            upY[e.idx] = longint'(bus.y);
            if (e.idx > 0) checkOutput("monotonic", (upY[e.idx] >= upY[e.idx-1]) ? 1 : 0, 1);
          end else if (e.kind == 2) begin
            dnY[e.idx] = longint'(bus.y);
          end
        end
        lastY = longint'(bus.y);
      end else begin
        checkOutput("y_hold", longint'(bus.y), lastY);
      end
    end
  end

  initial begin
    longint r5;
    cycle       = 0;
    passCount   = 0;
    checkCount  = 0;
    lastY       = 0;
    rst         = 1'b1;
    bus.in_valid = 1'b0;
    bus.x        = '0;
`ifdef SIGMOID_ROUND_EN
    r5 = 8383489;
`else
    r5 = 8383488;
`endif

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_out_valid", longint'(bus.out_valid), 0);
    checkOutput("reset_y", longint'(bus.y), 0);
    rst = 1'b0;

    $display("[TB] directed samples");
    applyStimulus(1'b1, 0, 8388608, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 0);
    applyStimulus(1'b1, 8192, 14680064, 0, 0);
    applyStimulus(1'b1, -8192, 2097152, 0, 0);
    applyStimulus(1'b1, 16384, ONE, 0, 0);
    applyStimulus(1'b1, 65535, ONE, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 0);
    applyStimulus(1'b1, -16384, 0, 0, 0);
    applyStimulus(1'b1, -65536, 0, 0, 0);
    applyStimulus(1'b1, 16383, ONE, 0, 0);
    applyStimulus(1'b1, -16383, 0, 0, 0);
    applyStimulus(1'b1, -5, r5, 0, 0);
    applyStimulus(1'b1, 5, ONE - r5, 0, 0);
    applyStimulus(1'b1, 1, ONE - 8387584, 0, 0);
    drain();

    $display("[TB] ascending and descending sweeps");
    for (int k = 0; k < NSWP; k++) begin
      applyStimulus(1'b1, -65535 + 100 * k, model(-65535 + 100 * k), 1, k);
    end
    for (int k = 0; k < NSWP; k++) begin
      applyStimulus(1'b1, 65535 - 100 * k, model(65535 - 100 * k), 2, k);
    end
    drain();
    for (int k = 0; k < NSWP; k++) begin
      checkOutput("symmetry", upY[k] + dnY[k], ONE);
    end

    $display("[TB] reset mid-stream");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1000 * k, model(1000 * k), 0, 0);
    end
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    sbQ.delete();
    lastY = 0;
    #1;
    checkOutput("async_reset_out_valid", longint'(bus.out_valid), 0);
    checkOutput("async_reset_y", longint'(bus.y), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 0);
    applyStimulus(1'b1, -8192, 2097152, 0, 0);
    applyStimulus(1'b1, 3000, model(3000), 0, 0);
    drain();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
